state_dump_unit: RTL and testbench
==================================

STATE_DUMP_UNIT -- requirements
Module: state_dump_unit

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 32, word width.
- NUM_REGS, 32, register-file entries scanned, 2..256.
- MEM_WORDS, 8, data-memory words scanned, 1..256.
- MODE, 0, 0 = one-shot (stay halted after dump), 1 = periodic.
- PERIOD, 20, run cycles before an automatic dump.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, asynchronous active-high reset.
- dump_req, in, 1, single-cycle manual dump request.
- pc_in, in, DATA_W, CPU program counter.
- halt, out, 1, stalls the CPU.
- rf_raddr, out, clog2(NUM_REGS), register read address.
- rf_rdata, in, DATA_W, register read data.
- dm_raddr, out, clog2(MEM_WORDS), data-memory word address.
- dm_rdata, in, DATA_W, data-memory read data.
- out_valid, out, 1, record valid.
- out_ready, in, 1, sink accepts the record.
- out_data, out, DATA_W, record payload.
- out_tag, out, 2, record type: 0 = cycle, 1 = PC, 2 = register, 3 = memory.
- out_index, out, 8, register or memory index; 0 for tags 0 and 1.
- out_last, out, 1, final record of the dump.
- busy, out, 1, dump in progress.
- cycle_count, out, 32, run-cycle counter.

Function
REQ-003 cycle_count SHALL increment by 1 on each clk edge while the FSM is in RUN, SHALL saturate at 0xFFFFFFFF, and SHALL hold during a dump.

REQ-004 The FSM states SHALL be RUN, HDR, PCW, ADDR, WAIT, EMIT and DONE.
- RUN SHALL exit to HDR on dump_req=1.
- RUN SHALL also exit to HDR on an automatic trigger: cycle_count reaches PERIOD (MODE=0), or cycle_count is a nonzero multiple of PERIOD (MODE=1).
- halt SHALL assert on the same edge that leaves RUN, and busy SHALL equal halt.

REQ-005 A dump_req arriving in the same cycle as an automatic trigger SHALL produce exactly one dump; dump_req SHALL be ignored in every state except RUN.

REQ-006 HDR SHALL present tag 0 with out_data equal to cycle_count; PCW SHALL present tag 1 with out_data equal to the pc_in value sampled on entry to HDR.

REQ-007 For each register index i = 0..NUM_REGS-1 and then each memory index j = 0..MEM_WORDS-1:
- ADDR SHALL drive the address.
- WAIT SHALL absorb one cycle of synchronous read latency.
- The read data SHALL be captured into the output register on the WAIT->EMIT edge.
- EMIT SHALL present tag 2 or 3 with the matching out_index.

REQ-008 Every record SHALL hold out_valid=1 with out_data, out_tag, out_index and out_last stable until a cycle with out_ready=1; the next step SHALL begin on that edge.
- Maximum throughput: one scanned word per 3 cycles.
- Zero-wait records (HDR, PCW) complete in 1 cycle when ready.

REQ-009 out_last SHALL be 1 only on memory index MEM_WORDS-1. A dump SHALL total 2+NUM_REGS+MEM_WORDS records, in fixed order.

REQ-010 After the last handshake:
- MODE=0 SHALL enter DONE and keep halt=1 until rst.
- MODE=1 SHALL return to RUN, deassert halt on that edge, and resume counting from the held value.

REQ-011 rf_raddr and dm_raddr SHALL be 0 outside ADDR and WAIT, and out_valid SHALL be 0 in RUN and DONE.

Reset
REQ-012 On rst=1 the block SHALL asynchronously set:
- FSM to RUN.
- cycle_count, halt, busy, out_valid, out_last, out_data, out_tag, out_index, rf_raddr and dm_raddr to 0.

REQ-013 An rst asserted mid-dump SHALL abandon the dump with no out_last emitted. The first dump after release SHALL restart from the header.

Structure
REQ-014 Package state_dump_pkg SHALL hold the tag encodings and the FSM state enum.

REQ-015 The valid/ready output holding register SHALL be the sub-module dump_out_reg; the counter, index scan and FSM SHALL stay in state_dump_unit.

Verification
REQ-016 One-shot auto trigger.
- Setup: NUM_REGS=4, MEM_WORDS=2, MODE=0, PERIOD=20, out_ready=1, rf[i]=i+1, dm[j]=0xA0+j.
- Required: halt rises on the edge where cycle_count=20; 8 records: (0,20), (1,PC), (2,1..4), (3,0xA0,0xA1); out_last only on the last record; halt stays 1.

REQ-017 Periodic mode.
- Setup: MODE=1, PERIOD=5.
- Required: dumps carry cycle values 5, 10 and 15; halt drops after each out_last.

REQ-018 Backpressure.
- Stimulus: out_ready=0 for 4 cycles during register index 2.
- Required: out_data=3, out_tag=2 and out_index=2 stay stable; the record is accepted once out_ready=1.

REQ-019 Simultaneous trigger.
- Stimulus: dump_req=1 in the same cycle cycle_count reaches PERIOD.
- Required: exactly one header record.

REQ-020 Manual trigger and ignored request.
- Stimulus: dump_req at cycle 7 (MODE=0, PERIOD=20), then dump_req again while busy.
- Required: header carries 7; the second request is ignored.

REQ-021 Mid-dump reset.
- Stimulus: rst during memory index 0.
- Required: all outputs 0 immediately; the next dump begins with a tag 0 record.

Source files
------------

// File: rtl/state_dump_pkg.sv
// Shared encodings for the state dump unit: record tags, FSM states and
// the address-width helper used by the scan ports.
package state_dump_pkg;

  typedef enum logic [1:0] {
    TAG_CYC = 2'd0,
    TAG_PC  = 2'd1,
    TAG_REG = 2'd2,
    TAG_MEM = 2'd3
  } tag_e;

  typedef enum logic [2:0] {
    S_RUN,
    S_HDR,
    S_PCW,
    S_ADDR,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_e;

  localparam int unsigned IDX_W = 8;

  // A single-entry array still gets a 1-bit address port.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/state_dump_if.sv
// Valid/ready record stream carrying dump records to the sink.
interface state_dump_if #(
  parameter int unsigned DATA_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_tag;
  logic [7:0]        out_index;
  logic              out_last;

  modport master (
    output out_valid, out_data, out_tag, out_index, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_tag, out_index, out_last,
    output out_ready
  );
endinterface

// File: rtl/state_dump_unit_out_reg.sv
// Output holding register: a loaded record stays valid and stable until the
// sink accepts it.
module dump_out_reg
  import state_dump_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] ld_data,
  input  tag_e              ld_tag,
  input  logic [IDX_W-1:0]  ld_index,
  input  logic              ld_last,
  output logic              accept,
  state_dump_if.master      rec
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [1:0]        tag_q,   tag_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic              last_q,  last_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;
    index_d = index_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = ld_data;
      tag_d   = ld_tag;
      index_d = ld_index;
      last_d  = ld_last;
    end else if (clear) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      index_q <= index_d;
      last_q  <= last_d;
    end
  end

  assign accept        = valid_q & rec.out_ready;
  assign rec.out_valid = valid_q;
  assign rec.out_data  = data_q;
  assign rec.out_tag   = tag_q;
  assign rec.out_index = index_q;
  assign rec.out_last  = last_q;

endmodule

// File: rtl/state_dump_unit.sv
// Halts the CPU and streams cycle count, PC, register file and data memory
// as tagged records, on request or automatically every PERIOD run cycles.
module state_dump_unit
  import state_dump_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned MEM_WORDS = 8,
  parameter int unsigned MODE      = 0,
  parameter int unsigned PERIOD    = 20
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dump_req,
  input  logic [DATA_W-1:0]             pc_in,
  output logic                          halt,
  output logic [addr_w(NUM_REGS)-1:0]   rf_raddr,
  input  logic [DATA_W-1:0]             rf_rdata,
  output logic [addr_w(MEM_WORDS)-1:0]  dm_raddr,
  input  logic [DATA_W-1:0]             dm_rdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [1:0]                    out_tag,
  output logic [7:0]                    out_index,
  output logic                          out_last,
  output logic                          busy,
  output logic [31:0]                   cycle_count
);

  localparam int unsigned RA_W = addr_w(NUM_REGS);
  localparam int unsigned MA_W = addr_w(MEM_WORDS);
  localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] LAST_MEM = IDX_W'(MEM_WORDS - 1);

  state_e            state_q, state_d;
  logic [31:0]       count_q, count_d;
  logic [31:0]       phase_q, phase_d;
  logic              halt_q, halt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              is_mem_q, is_mem_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [RA_W-1:0]   rf_raddr_q, rf_raddr_d;
  logic [MA_W-1:0]   dm_raddr_q, dm_raddr_d;

  logic              ld, clr, accept;
  logic [DATA_W-1:0] ld_data;
  tag_e              ld_tag;
  logic [IDX_W-1:0]  ld_index;
  logic              ld_last;
  logic              cnt_inc, auto_trig;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    phase_d    = phase_q;
    halt_d     = halt_q;
    idx_d      = idx_q;
    is_mem_d   = is_mem_q;
    pc_d       = pc_q;
    rf_raddr_d = '0;
    dm_raddr_d = '0;
    ld         = 1'b0;
    clr        = 1'b0;
    ld_data    = '0;
    ld_tag     = TAG_CYC;
    ld_index   = '0;
    ld_last    = 1'b0;
    cnt_inc    = 1'b0;
    auto_trig  = 1'b0;

    case (state_q)
      S_RUN: begin
        cnt_inc = (count_q != '1);
        if (cnt_inc) begin
          count_d = count_q + 32'd1;
          phase_d = (phase_q == 32'(PERIOD - 1)) ? '0 : phase_q + 32'd1;
        end
        // Periodic mode tracks count mod PERIOD in phase_q to avoid a divider.
        if (MODE == 0) auto_trig = cnt_inc && (count_d == 32'(PERIOD));
        else           auto_trig = cnt_inc && (phase_q == 32'(PERIOD - 1));
        if (dump_req || auto_trig) begin
          state_d = S_HDR;
          halt_d  = 1'b1;
          pc_d    = pc_in;
          ld      = 1'b1;
          ld_data = DATA_W'(count_d);
          ld_tag  = TAG_CYC;
        end
      end
      S_HDR: begin
        if (accept) begin
          state_d = S_PCW;
          ld      = 1'b1;
          ld_data = pc_q;
          ld_tag  = TAG_PC;
        end
      end
      S_PCW: begin
        if (accept) begin
          state_d  = S_ADDR;
          clr      = 1'b1;
          idx_d    = '0;
          is_mem_d = 1'b0;
        end
      end
      S_ADDR: begin
        state_d    = S_WAIT;
        rf_raddr_d = rf_raddr_q;
        dm_raddr_d = dm_raddr_q;
      end
      S_WAIT: begin
        state_d  = S_EMIT;
        ld       = 1'b1;
        ld_data  = is_mem_q ? dm_rdata : rf_rdata;
        ld_tag   = is_mem_q ? TAG_MEM : TAG_REG;
        ld_index = idx_q;
        ld_last  = is_mem_q && (idx_q == LAST_MEM);
      end
      S_EMIT: begin
        if (accept) begin
          clr = 1'b1;
          if (!is_mem_q && (idx_q == LAST_REG)) begin
            state_d  = S_ADDR;
            is_mem_d = 1'b1;
            idx_d    = '0;
          end else if (is_mem_q && (idx_q == LAST_MEM)) begin
            if (MODE == 0) begin
              state_d = S_DONE;
            end else begin
              state_d = S_RUN;
              halt_d  = 1'b0;
            end
          end else begin
            state_d = S_ADDR;
            idx_d   = idx_q + 8'd1;
            if (is_mem_q) dm_raddr_d = MA_W'(idx_q + 8'd1);
            else          rf_raddr_d = RA_W'(idx_q + 8'd1);
          end
        end
      end
      S_DONE: ;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RUN;
      count_q    <= '0;
      phase_q    <= '0;
      halt_q     <= 1'b0;
      idx_q      <= '0;
      is_mem_q   <= 1'b0;
      pc_q       <= '0;
      rf_raddr_q <= '0;
      dm_raddr_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      phase_q    <= phase_d;
      halt_q     <= halt_d;
      idx_q      <= idx_d;
      is_mem_q   <= is_mem_d;
      pc_q       <= pc_d;
      rf_raddr_q <= rf_raddr_d;
      dm_raddr_q <= dm_raddr_d;
    end
  end

  state_dump_if #(.DATA_W(DATA_W)) rec_if ();

  dump_out_reg #(.DATA_W(DATA_W)) u_out (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .clear    (clr),
    .ld_data  (ld_data),
    .ld_tag   (ld_tag),
    .ld_index (ld_index),
    .ld_last  (ld_last),
    .accept   (accept),
    .rec      (rec_if.master)
  );

  assign rec_if.out_ready = out_ready;
  assign out_valid        = rec_if.out_valid;
  assign out_data         = rec_if.out_data;
  assign out_tag          = rec_if.out_tag;
  assign out_index        = rec_if.out_index;
  assign out_last         = rec_if.out_last;

  assign halt        = halt_q;
  assign busy        = halt_q;
  assign cycle_count = count_q;
  assign rf_raddr    = rf_raddr_q;
  assign dm_raddr    = dm_raddr_q;

endmodule

// File: tb/tb_state_dump_unit.sv
// Directed bench: a one-shot unit (PERIOD 20) and a periodic unit (PERIOD 5),
// both with 4 registers and 2 memory words, checked against hand tables.
module tb_state_dump_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dump_req = 1'b0;
  logic [31:0] pc_in = '0;
  logic        sel = 1'b0;

  always #5 clk = ~clk;

  state_dump_if #(.DATA_W(32)) bus ();

  logic        halt0, busy0, halt1, busy1;
  logic [1:0]  rf_raddr0, rf_raddr1;
  logic [0:0]  dm_raddr0, dm_raddr1;
  logic [31:0] rf_rdata0, dm_rdata0, rf_rdata1, dm_rdata1;
  logic [31:0] cc0, cc1;
  logic        v1, l1;
  logic [31:0] d1;
  logic [1:0]  t1;
  logic [7:0]  i1;

  state_dump_unit #(.DATA_W(32), .NUM_REGS(4), .MEM_WORDS(2), .MODE(0), .PERIOD(20)) dut0 (
    .clk(clk), .rst(rst), .dump_req(dump_req), .pc_in(pc_in), .halt(halt0),
    .rf_raddr(rf_raddr0), .rf_rdata(rf_rdata0), .dm_raddr(dm_raddr0), .dm_rdata(dm_rdata0),
    .out_valid(bus.out_valid), .out_ready(bus.out_ready), .out_data(bus.out_data),
    .out_tag(bus.out_tag), .out_index(bus.out_index), .out_last(bus.out_last),
    .busy(busy0), .cycle_count(cc0)
  );

  state_dump_unit #(.DATA_W(32), .NUM_REGS(4), .MEM_WORDS(2), .MODE(1), .PERIOD(5)) dut1 (
    .clk(clk), .rst(rst), .dump_req(dump_req), .pc_in(pc_in), .halt(halt1),
    .rf_raddr(rf_raddr1), .rf_rdata(rf_rdata1), .dm_raddr(dm_raddr1), .dm_rdata(dm_rdata1),
    .out_valid(v1), .out_ready(bus.out_ready), .out_data(d1),
    .out_tag(t1), .out_index(i1), .out_last(l1),
    .busy(busy1), .cycle_count(cc1)
  );

  // Synchronous-read memories: rf[i] = i+1, dm[j] = 0xA0+j.
  always @(posedge clk) begin
    rf_rdata0 <= 32'(rf_raddr0) + 32'd1;
    dm_rdata0 <= 32'hA0 + 32'(dm_raddr0);
    rf_rdata1 <= 32'(rf_raddr1) + 32'd1;
    dm_rdata1 <= 32'hA0 + 32'(dm_raddr1);
  end

  logic        o_valid, o_last, o_halt, o_busy;
  logic [31:0] o_data, o_cc;
  logic [1:0]  o_tag;
  logic [7:0]  o_index;
  logic [2:0]  o_addr;

  always_comb begin
    o_valid = sel ? v1 : bus.out_valid;
    o_last  = sel ? l1 : bus.out_last;
    o_data  = sel ? d1 : bus.out_data;
    o_tag   = sel ? t1 : bus.out_tag;
    o_index = sel ? i1 : bus.out_index;
    o_halt  = sel ? halt1 : halt0;
    o_busy  = sel ? busy1 : busy0;
    o_cc    = sel ? cc1 : cc0;
    o_addr  = sel ? {rf_raddr1, dm_raddr1} : {rf_raddr0, dm_raddr0};
  end

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected record k of a dump (4 regs, 2 mem words).
  function automatic logic [31:0] exp_data(input int k, input logic [31:0] cyc, input logic [31:0] pc);
    if (k == 0) return cyc;
    if (k == 1) return pc;
    if (k < 6)  return 32'(k - 1);
    return 32'hA0 + 32'(k - 6);
  endfunction

  function automatic logic [31:0] exp_meta(input int k);
    logic [1:0] t;
    logic [7:0] i;
    t = (k == 0) ? 2'd0 : (k == 1) ? 2'd1 : (k < 6) ? 2'd2 : 2'd3;
    i = (k < 2) ? 8'd0 : (k < 6) ? 8'(k - 2) : 8'(k - 6);
    return {21'd0, (k == 7), t, i};
  endfunction

  task automatic wait_valid();
    for (int n = 0; n < 20 && !o_valid; n++) @(negedge clk);
  endtask

  task automatic run_dump(input logic [31:0] exp_cyc, input logic [31:0] exp_pc,
                          input int stall_at, input int req_at, input int n_recs,
                          input logic halt_after);
    for (int n = 0; n < 200 && !o_halt; n++) @(negedge clk);
    chk("halt_rise", 32'(o_halt), 32'd1);
    chk("busy_rise", 32'(o_busy), 32'd1);
    chk("cyc_at_halt", o_cc, exp_cyc);
    for (int k = 0; k < n_recs; k++) begin
      if (k == req_at) dump_req = 1'b1;
      if (k == stall_at) begin
        bus.out_ready = 1'b0;
        wait_valid();
        for (int s = 0; s < 4; s++) begin
          chk("hold_valid", 32'(o_valid), 32'd1);
          chk("hold_data", o_data, exp_data(k, exp_cyc, exp_pc));
          chk("hold_meta", {21'd0, o_last, o_tag, o_index}, exp_meta(k));
          @(negedge clk);
        end
        bus.out_ready = 1'b1;
      end
      wait_valid();
      chk("rec_valid", 32'(o_valid), 32'd1);
      chk("rec_data", o_data, exp_data(k, exp_cyc, exp_pc));
      chk("rec_meta", {21'd0, o_last, o_tag, o_index}, exp_meta(k));
      @(negedge clk);
      dump_req = 1'b0;
      if (k == 0) pc_in = ~pc_in;
    end
    if (n_recs == 8) begin
      chk("halt_after", 32'(o_halt), 32'(halt_after));
      chk("valid_after", 32'(o_valid), 32'd0);
      chk("cyc_held", o_cc, exp_cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_cc(input logic [31:0] v);
    for (int n = 0; n < 200 && o_cc != v; n++) @(negedge clk);
    chk("reach_cyc", o_cc, v);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {28'd0, o_halt, o_busy, o_valid, o_last}, 32'd0);
    chk({tag, "_data"}, o_data, 32'd0);
    chk({tag, "_meta"}, {22'd0, o_tag, o_index}, 32'd0);
    chk({tag, "_addr"}, 32'(o_addr), 32'd0);
    chk({tag, "_cyc"}, o_cc, 32'd0);
  endtask

  initial begin
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk_zero("reset");

    // One-shot auto trigger at 20; PC change after header entry must not leak.
    pc_in = 32'h0000_4000;
    rst = 1'b0;
    wait_cc(32'd19);
    chk("halt_pre", 32'(o_halt), 32'd0);
    run_dump(32'd20, 32'h0000_4000, -1, -1, 8, 1'b1);
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("done_halt", 32'(o_halt), 32'd1);
    chk("done_valid", 32'(o_valid), 32'd0);
    chk("done_cyc", o_cc, 32'd20);

    // Backpressure on register index 2.
    do_reset();
    pc_in = 32'h1234_5678;
    run_dump(32'd20, 32'h1234_5678, 4, -1, 8, 1'b1);

    // Manual request at cycle 7, second request while busy.
    do_reset();
    pc_in = 32'h0000_0700;
    wait_cc(32'd6);
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    run_dump(32'd7, 32'h0000_0700, -1, 2, 8, 1'b1);

    // Reset during memory index 0, then a fresh dump from the header.
    do_reset();
    pc_in = 32'h0000_0ABC;
    run_dump(32'd20, 32'h0000_0ABC, -1, -1, 6, 1'b1);
    wait_valid();
    chk("pre_rst_tag", 32'(o_tag), 32'd3);
    rst = 1'b1;
    #1;
    chk_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    pc_in = 32'h0000_0DEF;
    run_dump(32'd20, 32'h0000_0DEF, -1, -1, 8, 1'b1);

    // Periodic mode: dumps at 5, 10, 15 with halt released after each.
    sel = 1'b1;
    do_reset();
    pc_in = 32'h0000_0500;
    run_dump(32'd5, 32'h0000_0500, -1, -1, 8, 1'b0);
    pc_in = 32'h0000_1000;
    run_dump(32'd10, 32'h0000_1000, -1, -1, 8, 1'b0);
    pc_in = 32'h0000_1500;
    run_dump(32'd15, 32'h0000_1500, -1, -1, 8, 1'b0);

    // Request coinciding with the automatic trigger yields a single dump.
    do_reset();
    pc_in = 32'h0000_0055;
    wait_cc(32'd4);
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    run_dump(32'd5, 32'h0000_0055, -1, -1, 8, 1'b0);
    pc_in = 32'h0000_0066;
    run_dump(32'd10, 32'h0000_0066, -1, -1, 8, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
